// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches into IR, splits decode fields and
// computes the next PC from jump/branch triggers at the end of execute.
module pc_fetch_unit #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         INSTRUCTION,
  input  logic                IMEM_BUSYWAIT,
  input  logic                DMEM_BUSYWAIT,
  input  logic                J_TRIGGER,
  input  logic                BEQ_TRIGGER,
  input  logic                BNE_TRIGGER,
  input  logic                ZERO,
  output logic [PC_WIDTH-1:0] PC,
  output logic                IMEM_READ,
  output logic                INSTR_VALID,
  output logic [7:0]          OPCODE,
  output logic [2:0]          RD,
  output logic [2:0]          RT,
  output logic [2:0]          RS,
  output logic [7:0]          IMMEDIATE,
  output logic [7:0]          OFFSET
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic                valid_q, valid_d;

  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] target;
  logic                taken;
  logic                unused_ir;

  // Word offset sign-extended and scaled to bytes in one concatenation.
  assign pc_plus4 = pc_q + PC_WIDTH'(4);
  assign target   = pc_plus4 + {{(PC_WIDTH-10){ir_q[23]}}, ir_q[23:16], 2'b00};
  assign taken    = J_TRIGGER | (BEQ_TRIGGER & ZERO) | (BNE_TRIGGER & ~ZERO);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!IMEM_BUSYWAIT) begin
          ir_d    = INSTRUCTION;
          valid_d = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!DMEM_BUSYWAIT) begin
          pc_d    = taken ? target : pc_plus4;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  assign PC          = pc_q;
  assign IMEM_READ   = (state_q == S_FETCH);
  assign INSTR_VALID = valid_q;
  assign OPCODE      = ir_q[31:24];
  assign OFFSET      = ir_q[23:16];
  assign RD          = ir_q[18:16];
  assign RT          = ir_q[10:8];
  assign RS          = ir_q[2:0];
  assign IMMEDIATE   = ir_q[7:0];
  assign unused_ir   = ^ir_q[15:11];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, stalls, jumps/branches, wrap and mid-fetch reset.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET, IMEM_BUSYWAIT, DMEM_BUSYWAIT;
  logic        J_TRIGGER, BEQ_TRIGGER, BNE_TRIGGER, ZERO;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  logic        IMEM_READ, INSTR_VALID;
  logic [7:0]  OPCODE, IMMEDIATE, OFFSET;
  logic [2:0]  RD, RT, RS;

  int total = 0;
  int fails = 0;

  pc_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
    .J_TRIGGER(J_TRIGGER), .BEQ_TRIGGER(BEQ_TRIGGER), .BNE_TRIGGER(BNE_TRIGGER),
    .ZERO(ZERO), .PC(PC), .IMEM_READ(IMEM_READ), .INSTR_VALID(INSTR_VALID),
    .OPCODE(OPCODE), .RD(RD), .RT(RT), .RS(RS), .IMMEDIATE(IMMEDIATE), .OFFSET(OFFSET)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starting in S_FETCH with imem ready: fetch, execute with given triggers, check new PC.
  task automatic do_instr(input string tag, input logic [31:0] instr,
                          input logic j, input logic beq, input logic bne, input logic z,
                          input logic [31:0] exp_pc);
    INSTRUCTION = instr;
    tick();
    chk({tag, "_valid"}, {31'd0, INSTR_VALID}, 32'd1);
    J_TRIGGER = j; BEQ_TRIGGER = beq; BNE_TRIGGER = bne; ZERO = z;
    tick();
    J_TRIGGER = 0; BEQ_TRIGGER = 0; BNE_TRIGGER = 0; ZERO = 0;
    chk({tag, "_pc"}, PC, exp_pc);
    chk({tag, "_rd"}, {31'd0, IMEM_READ}, 32'd1);
  endtask

  initial begin
    RESET = 1; IMEM_BUSYWAIT = 0; DMEM_BUSYWAIT = 0;
    J_TRIGGER = 0; BEQ_TRIGGER = 0; BNE_TRIGGER = 0; ZERO = 0;
    INSTRUCTION = 32'h0;

    // 1: reset, boot, first fetch/exec
    tick(); tick();
    chk("rst_pc", PC, 32'h0);
    chk("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
    chk("rst_read", {31'd0, IMEM_READ}, 32'd0);
    chk("rst_opcode", {24'd0, OPCODE}, 32'h0);
    RESET = 0;
    tick();
    chk("boot_read", {31'd0, IMEM_READ}, 32'd1);
    chk("boot_valid", {31'd0, INSTR_VALID}, 32'd0);
    INSTRUCTION = 32'h3C0A0B0D;
    tick();
    chk("t1_valid", {31'd0, INSTR_VALID}, 32'd1);
    chk("t1_read", {31'd0, IMEM_READ}, 32'd0);
    chk("t1_opcode", {24'd0, OPCODE}, 32'h3C);
    chk("t1_rd", {29'd0, RD}, 32'd2);
    chk("t1_rt", {29'd0, RT}, 32'd3);
    chk("t1_rs", {29'd0, RS}, 32'd5);
    chk("t1_imm", {24'd0, IMMEDIATE}, 32'h0D);
    chk("t1_off", {24'd0, OFFSET}, 32'h0A);
    INSTRUCTION = 32'hDEADBEEF;
    tick();
    chk("t1_pc", PC, 32'h4);
    chk("t1_valid_lo", {31'd0, INSTR_VALID}, 32'd0);

    // 2: imem stall, triggers ignored while fetching
    IMEM_BUSYWAIT = 1; J_TRIGGER = 1; INSTRUCTION = 32'h40020000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_pc", PC, 32'h4);
      chk("t2_read", {31'd0, IMEM_READ}, 32'd1);
      chk("t2_valid", {31'd0, INSTR_VALID}, 32'd0);
    end
    J_TRIGGER = 0; IMEM_BUSYWAIT = 0;
    tick();
    chk("t2_valid_hi", {31'd0, INSTR_VALID}, 32'd1);
    chk("t2_opcode", {24'd0, OPCODE}, 32'h40);
    J_TRIGGER = 1;
    tick();
    J_TRIGGER = 0;
    chk("t2_jpc", PC, 32'h10);

    // 3: jumps
    do_instr("t3_jback", 32'h40FE0000, 1, 0, 0, 0, 32'h0C);
    do_instr("t3_seq",   32'h01000000, 0, 0, 0, 0, 32'h10);
    do_instr("t3_jfwd",  32'h40030000, 1, 0, 0, 0, 32'h20);

    // 4: conditional branches
    do_instr("t4_beq_t", 32'h50010000, 0, 1, 0, 1, 32'h28);
    do_instr("t4_jret",  32'h40FD0000, 1, 0, 0, 0, 32'h20);
    do_instr("t4_beq_n", 32'h50010000, 0, 1, 0, 0, 32'h24);
    do_instr("t4_bne_t", 32'h51010000, 0, 0, 1, 0, 32'h2C);
    do_instr("t4_bne_n", 32'h51010000, 0, 0, 1, 1, 32'h30);
    do_instr("t4_multi", 32'h40020000, 1, 1, 0, 0, 32'h3C);

    // 5: dmem stall in exec; imem busy there is ignored
    INSTRUCTION = 32'h77050000;
    tick();
    DMEM_BUSYWAIT = 1; IMEM_BUSYWAIT = 1; INSTRUCTION = 32'h11111111; J_TRIGGER = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_pc", PC, 32'h3C);
      chk("t5_valid", {31'd0, INSTR_VALID}, 32'd1);
      chk("t5_opcode", {24'd0, OPCODE}, 32'h77);
    end
    DMEM_BUSYWAIT = 0; IMEM_BUSYWAIT = 0; J_TRIGGER = 0;
    tick();
    chk("t5_pc_adv", PC, 32'h40);
    // dmem busy in fetch is ignored
    DMEM_BUSYWAIT = 1; INSTRUCTION = 32'h22000000;
    tick();
    chk("t5_fetch_dm", {31'd0, INSTR_VALID}, 32'd1);
    DMEM_BUSYWAIT = 0;
    tick();
    chk("t5_pc2", PC, 32'h44);

    // 6: reset mid-fetch with imem busy
    IMEM_BUSYWAIT = 1;
    tick();
    RESET = 1;
    tick();
    chk("t6_pc", PC, 32'h0);
    chk("t6_valid", {31'd0, INSTR_VALID}, 32'd0);
    chk("t6_read", {31'd0, IMEM_READ}, 32'd0);
    RESET = 0; IMEM_BUSYWAIT = 0;
    tick();
    do_instr("t6_self", 32'h40FF0000, 1, 0, 0, 0, 32'h0);
    do_instr("t6_neg",  32'h40FE0000, 1, 0, 0, 0, 32'hFFFFFFFC);
    do_instr("t6_wrap", 32'h01000000, 0, 0, 0, 0, 32'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
